mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 70 +++++++
 tb/tb_mem_port_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter onto one single-port synchronous RAM port with one-cycle read latency.
// Define MEM_PORT_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed priority to m0.
module mem_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  logic req0, req1, grant0, grant1, pick1;
  logic last_grant, rd_valid, rd_owner;
  logic [ADDR_W-1:0] addr_q;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // pick1 only matters on contention; in fixed-priority builds m0 always wins
  assign pick1 = RR_EN & ~last_grant;
  assign grant0 = reset_n & req0 & ~(req1 & pick1);
  assign grant1 = reset_n & req1 & (~req0 | pick1);
  assign m0_waitrequest = ~reset_n | (req0 & ~grant0);
  assign m1_waitrequest = ~reset_n | (req1 & ~grant1);
  assign mem_chipselect = grant0 | grant1;
  assign mem_write      = grant0 ? m0_write : (grant1 & m1_write);
  assign mem_address    = grant0 ? m0_address : grant1 ? m1_address : addr_q;
  assign mem_writedata  = grant1 ? m1_writedata : m0_writedata;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;
  assign m0_readdatavalid = rd_valid & ~rd_owner;
  assign m1_readdatavalid = rd_valid & rd_owner;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      last_grant <= 1'b1;
      rd_valid   <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (mem_chipselect) addr_q <= mem_address;
      if (mem_chipselect) last_grant <= grant1;
      rd_valid <= mem_chipselect & ~mem_write;
      rd_owner <= grant1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural one-cycle-latency RAM.
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset_n;
  logic [10:0] m0_address, m1_address, mem_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata;
  logic [15:0] mem_readdata = '0;
  logic [1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic mem_chipselect, mem_write;
  logic [15:0] ram [0:2047];
  int tests = 0, fails = 0;
  int g [4];
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata)
  );
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      if (mem_byteenable[0]) ram[mem_address][7:0] <= mem_writedata[7:0];
      if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
    end
    mem_readdata <= ram[mem_address];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv0(input logic r, input logic w, input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
    m0_read = r; m0_write = w; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask
  task automatic drv1(input logic r, input logic w, input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
    m1_read = r; m1_write = w; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask
  initial begin
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    g = '{0, 1, 0, 1};
`else
    g = '{0, 0, 0, 0};
`endif
    reset_n = 1'b0;
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    @(negedge clk); drv0(1, 0, 11'h123, 0, 2'b11); #1;
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_we", mem_write, 0);
    chk("rst_addr", mem_address, 0);
    @(negedge clk); reset_n = 1'b1; drv0(0, 1, 11'h7FF, 16'hFFFF, 2'b11); #1;
    chk("first_wait0", m0_waitrequest, 0);
    chk("first_cs", mem_chipselect, 1);
    chk("first_we", mem_write, 1);
    chk("first_addr", mem_address, 11'h7FF);
    @(negedge clk); drv0(0, 1, 11'h005, 16'hBEEF, 2'b11); #1;
    chk("wr_wait0", m0_waitrequest, 0);
    chk("wr_data", mem_writedata, 16'hBEEF);
    chk("wr_be", mem_byteenable, 2'b11);
    @(negedge clk); drv0(1, 0, 11'h005, 0, 2'b11); #1;
    chk("rd_wait0", m0_waitrequest, 0);
    chk("rd_we", mem_write, 0);
    chk("rd_cs", mem_chipselect, 1);
    @(negedge clk); drv0(0, 0, 0, 0, 0); #1;
    chk("rd_rdv0", m0_readdatavalid, 1);
    chk("rd_data0", m0_readdata, 16'hBEEF);
    chk("rd_rdv1", m1_readdatavalid, 0);
    chk("idle_cs", mem_chipselect, 0);
    chk("idle_addr_hold", mem_address, 11'h005);
    chk("idle_wait0", m0_waitrequest, 0);
    @(negedge clk); #1;
    chk("rd_rdv0_once", m0_readdatavalid, 0);
    @(negedge clk); drv0(0, 1, 11'h7FF, 16'h1234, 2'b01); #1;
    chk("be_lane", mem_byteenable, 2'b01);
    @(negedge clk); drv0(1, 0, 11'h7FF, 0, 2'b11);
    @(negedge clk); drv0(0, 0, 0, 0, 0); #1;
    chk("be_rdv0", m0_readdatavalid, 1);
    chk("be_data", m0_readdata, 16'hFF34);
    @(negedge clk); drv1(0, 1, 11'h010, 16'h1111, 2'b11); #1;
    chk("m1_wr_wait1", m1_waitrequest, 0);
    @(negedge clk); drv1(0, 1, 11'h020, 16'h2222, 2'b11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drv0(1, 0, 11'h010, 0, 2'b11); drv1(1, 0, 11'h020, 0, 2'b11); #1;
      chk($sformatf("cont%0d_wait0", i), m0_waitrequest, g[i] == 1);
      chk($sformatf("cont%0d_wait1", i), m1_waitrequest, g[i] == 0);
      chk($sformatf("cont%0d_addr", i), mem_address, g[i] == 1 ? 11'h020 : 11'h010);
      if (i > 0) begin
        chk($sformatf("cont%0d_rdv0", i), m0_readdatavalid, g[i-1] == 0);
        chk($sformatf("cont%0d_rdv1", i), m1_readdatavalid, g[i-1] == 1);
        chk($sformatf("cont%0d_data", i), m0_readdata, g[i-1] == 1 ? 16'h2222 : 16'h1111);
      end
    end
    @(negedge clk); drv0(0, 0, 0, 0, 0); #1;
    chk("solo_wait1", m1_waitrequest, 0);
    chk("cont3_rdv0", m0_readdatavalid, g[3] == 0);
    chk("cont3_rdv1", m1_readdatavalid, g[3] == 1);
    @(negedge clk); drv1(0, 0, 0, 0, 0); #1;
    chk("solo_rdv1", m1_readdatavalid, 1);
    chk("solo_data1", m1_readdata, 16'h2222);
    @(negedge clk); drv0(1, 1, 11'h100, 16'h00AA, 2'b11); #1;
    chk("rw_we", mem_write, 1);
    chk("rw_wait0", m0_waitrequest, 0);
    @(negedge clk); drv0(1, 0, 11'h100, 0, 2'b11); #1;
    chk("rw_no_rdv0", m0_readdatavalid, 0);
    @(negedge clk); drv0(0, 0, 0, 0, 0); #1;
    chk("rw_rdv0", m0_readdatavalid, 1);
    chk("rw_data", m0_readdata, 16'h00AA);
    @(negedge clk); drv1(1, 0, 11'h020, 0, 2'b11); #1;
    chk("mid_wait1", m1_waitrequest, 0);
    chk("mid_cs", mem_chipselect, 1);
    @(posedge clk); reset_n = 1'b0; #1;
    chk("mid_rdv1", m1_readdatavalid, 0);
    chk("mid_rst_wait0", m0_waitrequest, 1);
    chk("mid_rst_wait1", m1_waitrequest, 1);
    chk("mid_rst_cs", mem_chipselect, 0);
    chk("mid_rst_we", mem_write, 0);
    chk("mid_rst_addr", mem_address, 0);
    @(negedge clk); #1;
    chk("mid_rdv1_late", m1_readdatavalid, 0);
    @(negedge clk); reset_n = 1'b1; drv0(1, 0, 11'h010, 0, 2'b11); #1;
    chk("post_wait0", m0_waitrequest, 0);
    chk("post_wait1", m1_waitrequest, 1);
    @(negedge clk); drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0); #1;
    chk("post_rdv0", m0_readdatavalid, 1);
    chk("post_data0", m0_readdata, 16'h1111);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
